// File: rtl/mem_seq_ctrl_if.sv
// Request/strobe bundle between the memory sequencer and its requesters/DRAM path.
interface mem_seq_ctrl_if;
    logic       fetch_req;
    logic       vec_req;
    logic       vec_wr;
    logic       setPC;
    logic       updateAddr;
    logic [3:0] inc_offset;
    logic       mem_rd;
    logic       mem_wr;
    logic [3:0] elem_idx;
    logic       fetch_ack;
    logic       vec_done;
    logic       vec_busy;

    modport master (
        output fetch_req, vec_req, vec_wr,
        input  setPC, updateAddr, inc_offset, mem_rd, mem_wr,
               elem_idx, fetch_ack, vec_done, vec_busy
    );

    modport slave (
        input  fetch_req, vec_req, vec_wr,
        output setPC, updateAddr, inc_offset, mem_rd, mem_wr,
               elem_idx, fetch_ack, vec_done, vec_busy
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Memory sequencer: arbitrates instruction fetch against vector load/store
// (round-robin on ties) and steps DRAM address/strobe control per element.
module mem_seq_ctrl #(
    parameter int unsigned VLEN = 8
) (
    input  logic          Clk1,
    input  logic          Reset,
    mem_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_ADDR = 3'd1,
        F_ACC  = 3'd2,
        V_ADDR = 3'd3,
        V_ACC  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(VLEN - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    logic       r_vec_wr;
    logic       w_vec_wr_nxt;
    logic       r_last_vec;      // 1 = vector was the last requester served
    logic       w_last_vec_nxt;
    logic       w_grant_fetch;
    logic       w_grant_vec;

    // On a tie the requester not served last wins; a lone request always wins.
    assign w_grant_fetch = bus.fetch_req && (!bus.vec_req || r_last_vec);
    assign w_grant_vec   = bus.vec_req && (!bus.fetch_req || !r_last_vec);

    // State, element index, latched direction and arbitration history.
    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_vec_wr   <= 1'b0;
            r_last_vec <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_vec_wr   <= w_vec_wr_nxt;
            r_last_vec <= w_last_vec_nxt;
        end
    end

    // Next-state: requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_vec_wr_nxt   = r_vec_wr;
        w_last_vec_nxt = r_last_vec;
        case (r_state)
            IDLE: begin
                if (w_grant_fetch) begin
                    w_state_nxt    = F_ADDR;
                    w_last_vec_nxt = 1'b0;
                end else if (w_grant_vec) begin
                    w_state_nxt    = V_ADDR;
                    w_vec_wr_nxt   = bus.vec_wr;
                    w_idx_nxt      = '0;
                    w_last_vec_nxt = 1'b1;
                end
            end
            F_ADDR: w_state_nxt = F_ACC;
            F_ACC:  w_state_nxt = IDLE;
            V_ADDR: w_state_nxt = V_ACC;
            V_ACC: begin
                if (r_idx == LAST_IDX) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = V_ADDR;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        bus.setPC      = 1'b0;
        bus.updateAddr = 1'b0;
        bus.inc_offset = '0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.elem_idx   = '0;
        bus.fetch_ack  = 1'b0;
        bus.vec_done   = 1'b0;
        bus.vec_busy   = 1'b0;
        case (r_state)
            F_ADDR: bus.setPC = 1'b1;
            F_ACC: begin
                bus.mem_rd    = 1'b1;
                bus.fetch_ack = 1'b1;
            end
            V_ADDR: begin
                bus.updateAddr = 1'b1;
                bus.inc_offset = r_idx;
                bus.vec_busy   = 1'b1;
            end
            V_ACC: begin
                bus.mem_rd   = !r_vec_wr;
                bus.mem_wr   = r_vec_wr;
                bus.elem_idx = r_idx;
                bus.vec_busy = 1'b1;
                bus.vec_done = (r_idx == LAST_IDX);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: VLEN = 8 main instance plus VLEN = 16 and 1.
module tb_mem_seq_ctrl;

    logic Clk1 = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk1 = ~Clk1;

    mem_seq_ctrl_if b8 ();
    mem_seq_ctrl_if b16 ();
    mem_seq_ctrl_if b1 ();

    mem_seq_ctrl #(.VLEN(8))  u_dut8  (.Clk1(Clk1), .Reset(Reset), .bus(b8.slave));
    mem_seq_ctrl #(.VLEN(16)) u_dut16 (.Clk1(Clk1), .Reset(Reset), .bus(b16.slave));
    mem_seq_ctrl #(.VLEN(1))  u_dut1  (.Clk1(Clk1), .Reset(Reset), .bus(b1.slave));

    // Packed view: {setPC, updateAddr, inc_offset, mem_rd, mem_wr, elem_idx, fetch_ack, vec_done, vec_busy}
    logic [14:0] o8, o16, o1;
    assign o8  = {b8.setPC, b8.updateAddr, b8.inc_offset, b8.mem_rd, b8.mem_wr,
                  b8.elem_idx, b8.fetch_ack, b8.vec_done, b8.vec_busy};
    assign o16 = {b16.setPC, b16.updateAddr, b16.inc_offset, b16.mem_rd, b16.mem_wr,
                  b16.elem_idx, b16.fetch_ack, b16.vec_done, b16.vec_busy};
    assign o1  = {b1.setPC, b1.updateAddr, b1.inc_offset, b1.mem_rd, b1.mem_wr,
                  b1.elem_idx, b1.fetch_ack, b1.vec_done, b1.vec_busy};

    function automatic logic [14:0] ex(input logic setpc, input logic upd, input logic [3:0] inc,
                                       input logic rd, input logic wr, input logic [3:0] el,
                                       input logic ack, input logic done, input logic busy);
        return {setpc, upd, inc, rd, wr, el, ack, done, busy};
    endfunction

    task automatic tick;
        @(posedge Clk1);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        b8.fetch_req = 1'b0;  b8.vec_req = 1'b0;  b8.vec_wr = 1'b0;
        b16.fetch_req = 1'b0; b16.vec_req = 1'b0; b16.vec_wr = 1'b0;
        b1.fetch_req = 1'b0;  b1.vec_req = 1'b0;  b1.vec_wr = 1'b0;
        tick();
        b8.fetch_req = 1'b1;
        b8.vec_req   = 1'b1;
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL reset_hold8 got %h want %h", o8, 15'd0);
        end
        checks++;
        if ({o16, o1} !== 30'd0) begin
            errors++;
            $display("FAIL reset_hold16_1 got %h want %h", {o16, o1}, 30'd0);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL reset_first_cycle got %h want %h", o8, 15'd0);
        end
        b8.fetch_req = 1'b0;
        b8.vec_req   = 1'b0;
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", o8, 15'd0);
        end
    endtask

    task automatic test_fetch;
        b8.fetch_req = 1'b1;
        tick();
        checks++;
        if (o8 !== ex(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL fetch_setpc got %h want %h", o8, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        b8.fetch_req = 1'b0;
        checks++;
        if (o8 !== ex(0, 0, 0, 1, 0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL fetch_ack got %h want %h", o8, ex(0, 0, 0, 1, 0, 0, 1, 0, 0));
        end
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL fetch_idle got %h want %h", o8, 15'd0);
        end
    endtask

    task automatic test_vec_load;
        b8.vec_wr  = 1'b0;
        b8.vec_req = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (o8 !== ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1)) begin
                errors++;
                $display("FAIL vload_addr e=%0d got %h want %h", e, o8, ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1));
            end
            tick();
            if (e == 7) b8.vec_req = 1'b0;
            checks++;
            if (o8 !== ex(0, 0, 0, 1, 0, 4'(e), 0, e == 7, 1)) begin
                errors++;
                $display("FAIL vload_acc e=%0d got %h want %h", e, o8, ex(0, 0, 0, 1, 0, 4'(e), 0, e == 7, 1));
            end
        end
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL vload_idle got %h want %h", o8, 15'd0);
        end
    endtask

    task automatic test_store_toggle;
        b8.vec_wr  = 1'b1;
        b8.vec_req = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            b8.vec_wr = 1'b0;
            checks++;
            if (o8 !== ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1)) begin
                errors++;
                $display("FAIL vstore_addr e=%0d got %h want %h", e, o8, ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1));
            end
            tick();
            if (e == 7) b8.vec_req = 1'b0;
            checks++;
            if (o8 !== ex(0, 0, 0, 0, 1, 4'(e), 0, e == 7, 1)) begin
                errors++;
                $display("FAIL vstore_acc e=%0d got %h want %h", e, o8, ex(0, 0, 0, 0, 1, 4'(e), 0, e == 7, 1));
            end
        end
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL vstore_idle got %h want %h", o8, 15'd0);
        end
    endtask

    // Fresh reset, then a tie: fetch first, vector next, fetch again (round-robin, back-to-back).
    task automatic test_tie;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        b8.vec_wr    = 1'b0;
        b8.fetch_req = 1'b1;
        b8.vec_req   = 1'b1;
        tick();
        checks++;
        if (o8 !== ex(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL tie_fetch_first got %h want %h", o8, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        checks++;
        if (o8 !== ex(0, 0, 0, 1, 0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL tie_fetch_ack got %h want %h", o8, ex(0, 0, 0, 1, 0, 0, 1, 0, 0));
        end
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL tie_gap got %h want %h", o8, 15'd0);
        end
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (o8 !== ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1)) begin
                errors++;
                $display("FAIL tie_vec_addr e=%0d got %h want %h", e, o8, ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1));
            end
            tick();
            if (e == 7) b8.vec_req = 1'b0;
            checks++;
            if (o8 !== ex(0, 0, 0, 1, 0, 4'(e), 0, e == 7, 1)) begin
                errors++;
                $display("FAIL tie_vec_acc e=%0d got %h want %h", e, o8, ex(0, 0, 0, 1, 0, 4'(e), 0, e == 7, 1));
            end
        end
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL tie_gap2 got %h want %h", o8, 15'd0);
        end
        tick();
        checks++;
        if (o8 !== ex(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL tie_refetch got %h want %h", o8, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        b8.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        b8.vec_wr  = 1'b0;
        b8.vec_req = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (o8 !== ex(0, 0, 0, 1, 0, 3, 0, 0, 1)) begin
            errors++;
            $display("FAIL rmid_at_idx3 got %h want %h", o8, ex(0, 0, 0, 1, 0, 3, 0, 0, 1));
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL rmid_async got %h want %h", o8, 15'd0);
        end
        b8.vec_req = 1'b0;
        tick();
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL rmid_held got %h want %h", o8, 15'd0);
        end
        Reset = 1'b0;
        b8.vec_req = 1'b1;
        #1;
        checks++;
        if (o8 !== 15'd0) begin
            errors++;
            $display("FAIL rmid_release got %h want %h", o8, 15'd0);
        end
        tick();
        checks++;
        if (o8 !== ex(0, 1, 0, 0, 0, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL rmid_restart got %h want %h", o8, ex(0, 1, 0, 0, 0, 0, 0, 0, 1));
        end
        tick();
        checks++;
        if (o8 !== ex(0, 0, 0, 1, 0, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL rmid_restart_acc got %h want %h", o8, ex(0, 0, 0, 1, 0, 0, 0, 0, 1));
        end
        b8.vec_req = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_vlen16;
        b16.vec_wr  = 1'b0;
        b16.vec_req = 1'b1;
        for (int e = 0; e < 16; e++) begin
            tick();
            checks++;
            if (o16 !== ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1)) begin
                errors++;
                $display("FAIL v16_addr e=%0d got %h want %h", e, o16, ex(0, 1, 4'(e), 0, 0, 0, 0, 0, 1));
            end
            tick();
            if (e == 15) b16.vec_req = 1'b0;
            checks++;
            if (o16 !== ex(0, 0, 0, 1, 0, 4'(e), 0, e == 15, 1)) begin
                errors++;
                $display("FAIL v16_acc e=%0d got %h want %h", e, o16, ex(0, 0, 0, 1, 0, 4'(e), 0, e == 15, 1));
            end
        end
        tick();
        checks++;
        if (o16 !== 15'd0) begin
            errors++;
            $display("FAIL v16_idle got %h want %h", o16, 15'd0);
        end
    endtask

    task automatic test_vlen1;
        b1.vec_wr  = 1'b1;
        b1.vec_req = 1'b1;
        tick();
        checks++;
        if (o1 !== ex(0, 1, 0, 0, 0, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL v1_addr got %h want %h", o1, ex(0, 1, 0, 0, 0, 0, 0, 0, 1));
        end
        tick();
        b1.vec_req = 1'b0;
        checks++;
        if (o1 !== ex(0, 0, 0, 0, 1, 0, 0, 1, 1)) begin
            errors++;
            $display("FAIL v1_done got %h want %h", o1, ex(0, 0, 0, 0, 1, 0, 0, 1, 1));
        end
        tick();
        checks++;
        if (o1 !== 15'd0) begin
            errors++;
            $display("FAIL v1_idle got %h want %h", o1, 15'd0);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_vec_load();
        test_store_toggle();
        test_tie();
        test_reset_mid();
        test_vlen16();
        test_vlen1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 Parameter: VLEN, default 8, number of elements per vector access; legal range 1..16.
REQ-002 Clk1  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 fetch_req  input  1  instruction-fetch request; held high until fetch_ack.
REQ-005 vec_req  input  1  vector load/store request; held high until vec_done.
REQ-006 vec_wr  input  1  vector direction: 1 = store, 0 = load; sampled only at grant.
REQ-007 setPC  output  1  load PC into DRAM address register.
REQ-008 updateAddr  output  1  load base + immediate + inc_offset into DRAM address register.
REQ-009 inc_offset  output  4  element offset for the current vector element.
REQ-010 mem_rd  output  1  DRAM read strobe.
REQ-011 mem_wr  output  1  DRAM write strobe.
REQ-012 elem_idx  output  4  element index of the current access, for register-file steering.
REQ-013 fetch_ack  output  1  one-cycle pulse; fetch word valid on DRAM data this cycle.
REQ-014 vec_done  output  1  one-cycle pulse on the final element access.
REQ-015 vec_busy  output  1  high from vector grant through the vec_done cycle.

Function
REQ-016 States: IDLE, F_ADDR, F_ACC, V_ADDR, V_ACC; encoded state register.
REQ-017 IDLE: all strobes low; inc_offset = 0; elem_idx = 0.
REQ-018 IDLE, only fetch_req high -> F_ADDR next cycle.
REQ-019 IDLE, only vec_req high -> V_ADDR next cycle; latch vec_wr; idx = 0.
REQ-020 IDLE, both requests high -> grant the requester NOT served last (round-robin); last_served updates at each grant.
REQ-021 F_ADDR: setPC = 1 for exactly one cycle; next state F_ACC.
REQ-022 F_ACC: mem_rd = 1, fetch_ack = 1; next state IDLE.
REQ-023 V_ADDR: updateAddr = 1; inc_offset = idx; next state V_ACC.
REQ-024 V_ACC: mem_rd = !vec_wr_latched, mem_wr = vec_wr_latched; elem_idx = idx.
REQ-025 V_ACC with idx == VLEN-1: vec_done = 1; idx cleared to 0; next state IDLE.
REQ-026 V_ACC with idx < VLEN-1: idx increments by 1; next state V_ADDR.
REQ-027 Latency: fetch grant to fetch_ack = 2 cycles; vector grant to vec_done = 2*VLEN cycles.
REQ-028 setPC and updateAddr never both high; mem_rd and mem_wr never both high.
REQ-029 Requests are sampled only in IDLE; a request dropped mid-operation does not abort it.
REQ-030 vec_wr changes after grant have no effect until the next grant.
REQ-031 Back-to-back: a request still high in the IDLE cycle following completion is granted in that cycle; IDLE lasts at least one cycle between operations.
REQ-032 idx is 4 bits; VLEN = 16 terminates at idx = 15 without wrap.
REQ-033 All outputs are decoded from registered state only; no combinational path from request inputs to outputs.

Reset
REQ-034 Reset high asynchronously forces state IDLE, idx = 0, vec_wr_latched = 0, last_served = vector (fetch wins the first tie).
REQ-035 During reset and in the first cycle after deassertion, all outputs are 0.
REQ-036 Reset mid-operation abandons the transfer; no fetch_ack or vec_done pulse is issued for it.

Verification
REQ-037 Fetch only: fetch_req = 1 from IDLE -> setPC at cycle 1, mem_rd and fetch_ack at cycle 2, IDLE at cycle 3.
REQ-038 Vector load, VLEN = 8: vec_req = 1, vec_wr = 0 -> 8 updateAddr/mem_rd pairs with inc_offset 0..7; vec_done at cycle 16; mem_wr stays 0.
REQ-039 Tie after reset: both requests high -> fetch granted first; vector granted in the IDLE cycle after fetch_ack.
REQ-040 Store with vec_wr toggled after grant: vec_wr = 1 at grant, then 0 -> all 8 accesses assert mem_wr, never mem_rd.
REQ-041 Reset at V_ACC with idx = 3 -> outputs 0 immediately; no vec_done; next vec_req restarts at inc_offset 0.
REQ-042 VLEN = 16 and VLEN = 1: inc_offset reaches 15, vec_done at cycle 32; VLEN = 1 gives vec_done at cycle 2.
